// File: rtl/oai221_pkg.sv
// Shared definitions for the OAI221 cell bank: golden truth table,
// self-test vector bit ordering, BIST states and the reference gate function.
package oai221_pkg;

    localparam logic [31:0] OAI221_GOLDEN = 32'h111F_FFFF;

    // Self-test vector index layout {A,B1,B2,C1,C2}, A is the MSB
    localparam int VEC_BITS  = 5;
    localparam int VEC_COUNT = 32;
    localparam int IDX_A     = 4;
    localparam int IDX_B1    = 3;
    localparam int IDX_B2    = 2;
    localparam int IDX_C1    = 1;
    localparam int IDX_C2    = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_FLUSH,
        ST_DONE
    } bist_state_t;

    function automatic logic oai221_f(input logic a, input logic b1, input logic b2,
                                      input logic c1, input logic c2);
        return ~(a & (b1 | b2) & (c1 | c2));
    endfunction

endpackage

// File: rtl/oai221_cell_bank_lane.sv
// Single OAI221 gate: zn = ~(a & (b1 | b2) & (c1 | c2)).
module oai221_lane
    import oai221_pkg::*;
(
    input  logic a,
    input  logic b1,
    input  logic b2,
    input  logic c1,
    input  logic c2,
    output logic zn
);

    assign zn = oai221_f(a, b1, b2, c1, c2);

endmodule

// File: rtl/oai221_cell_bank.sv
// Bank of WIDTH OAI221 lanes with a registered copy, valid tracking and an
// exhaustive built-in self-test that sweeps all 32 input vectors through every lane.
module oai221_cell_bank
    import oai221_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter logic [31:0] GOLDEN = OAI221_GOLDEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    output logic [WIDTH-1:0] zn,
    output logic [WIDTH-1:0] zn_q,
    output logic             out_valid,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass
);

    bist_state_t         state;
    logic [VEC_BITS-1:0] vec;
    logic                fail;
    logic                drive_bist;
    logic [WIDTH-1:0]    lane_d;
    logic                cmp_en;
    logic [VEC_BITS-1:0] cmp_idx;
    logic                mismatch;

    assign drive_bist = (state == ST_SWEEP);

    // Each lane has a functional copy feeding zn (never gated by BIST) and a
    // second copy whose inputs are taken over by the sweep vector for zn_q.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic ta, tb1, tb2, tc1, tc2;

        assign ta  = drive_bist ? vec[IDX_A]  : a[gi];
        assign tb1 = drive_bist ? vec[IDX_B1] : b1[gi];
        assign tb2 = drive_bist ? vec[IDX_B2] : b2[gi];
        assign tc1 = drive_bist ? vec[IDX_C1] : c1[gi];
        assign tc2 = drive_bist ? vec[IDX_C2] : c2[gi];

        oai221_lane u_func (
            .a  (a[gi]),
            .b1 (b1[gi]),
            .b2 (b2[gi]),
            .c1 (c1[gi]),
            .c2 (c2[gi]),
            .zn (zn[gi])
        );

        oai221_lane u_reg (
            .a  (ta),
            .b1 (tb1),
            .b2 (tb2),
            .c1 (tc1),
            .c2 (tc2),
            .zn (lane_d[gi])
        );
    end

    // zn_q holds the result of the previous vector; in FLUSH that is vector 31
    always_comb begin
        cmp_en   = 1'b0;
        cmp_idx  = vec - 1'b1;
        mismatch = 1'b0;
        if (state == ST_FLUSH) begin
            cmp_en  = 1'b1;
            cmp_idx = VEC_BITS'(VEC_COUNT - 1);
        end else if (state == ST_SWEEP && vec != '0) begin
            cmp_en = 1'b1;
        end
        if (cmp_en && (zn_q != {WIDTH{GOLDEN[cmp_idx]}})) begin
            mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            vec       <= '0;
            fail      <= 1'b0;
            zn_q      <= '1;
            out_valid <= 1'b0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    bist_done <= 1'b0;
                    zn_q      <= lane_d;
                    if (bist_start) begin
                        state     <= ST_SWEEP;
                        vec       <= '0;
                        fail      <= 1'b0;
                        bist_pass <= 1'b0;
                        bist_busy <= 1'b1;
                        out_valid <= 1'b0;
                    end else begin
                        state     <= ST_IDLE;
                        out_valid <= in_valid;
                    end
                end
                ST_SWEEP: begin
                    zn_q      <= lane_d;
                    out_valid <= 1'b0;
                    vec       <= vec + 1'b1;
                    if (mismatch) begin
                        fail <= 1'b1;
                    end
                    if (vec == VEC_BITS'(VEC_COUNT - 1)) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state     <= ST_DONE;
                    out_valid <= 1'b0;
                    fail      <= fail | mismatch;
                    bist_pass <= ~(fail | mismatch);
                    bist_busy <= 1'b0;
                    bist_done <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oai221_cell_bank.sv
// Directed self-checking bench for oai221_cell_bank: functional truth table,
// independent lanes, self-test pass/fail, reset abort and start collisions.
module tb_oai221_cell_bank;

    localparam int W = 8;
    // Hand-derived truth table: zn=0 only for A=1, B nibble bits nonzero, C bits nonzero
    localparam logic [31:0] EXP_ZN = 32'h111F_FFFF;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a, b1, b2, c1, c2;
    logic [W-1:0] zn, zn_q;
    logic         out_valid, bist_start, bist_busy, bist_done, bist_pass;
    logic [W-1:0] zn_b, zn_q_b;
    logic         out_valid_b, bist_start_b, bist_busy_b, bist_done_b, bist_pass_b;

    int checks   = 0;
    int failures = 0;

    oai221_cell_bank #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
        .zn(zn), .zn_q(zn_q), .out_valid(out_valid),
        .bist_start(bist_start), .bist_busy(bist_busy),
        .bist_done(bist_done), .bist_pass(bist_pass)
    );

    oai221_cell_bank #(.WIDTH(W), .GOLDEN(32'h111F_FFFE)) dut_bad (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b1(b1), .b2(b2), .c1(c1), .c2(c2),
        .zn(zn_b), .zn_q(zn_q_b), .out_valid(out_valid_b),
        .bist_start(bist_start_b), .bist_busy(bist_busy_b),
        .bist_done(bist_done_b), .bist_pass(bist_pass_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses bist_start on the main DUT and records what happens over 60 cycles
    task automatic run_bist(input int restart_at, output int busy_cycles,
                            output int done_cnt, output int done_at,
                            output int ov_busy, output logic [W-1:0] zn_mid,
                            output logic pass_at0);
        busy_cycles = 0;
        done_cnt    = 0;
        done_at     = -1;
        ov_busy     = 0;
        zn_mid      = '0;
        pass_at0    = 1'b0;
        bist_start  = 1'b1;
        tick();
        bist_start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bist_start = (i == restart_at);
            if (i == 0) pass_at0 = bist_pass;
            if (i == 16) zn_mid = zn;
            if (bist_busy) busy_cycles++;
            if (bist_busy && out_valid) ov_busy++;
            if (bist_done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            tick();
        end
        bist_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks += 6;
        if (zn_q !== 8'hFF) begin failures++; $display("[TB] FAIL reset_zn_q: got %h expected ff", zn_q); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (bist_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bist_busy); end
        if (bist_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bist_done); end
        if (bist_pass !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass: got %b expected 0", bist_pass); end
        if (bist_pass_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_pass_b: got %b expected 0", bist_pass_b); end
        rst_n = 1'b1;
        a = 8'hFF; b1 = 8'hFF; b2 = 8'h00; c1 = 8'hFF; c2 = 8'h00; in_valid = 1'b1;
        tick();
        checks += 2;
        if (zn_q !== 8'h00) begin failures++; $display("[TB] FAIL pre_reset_zn_q: got %h expected 00", zn_q); end
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_out_valid: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (zn_q !== 8'hFF) begin failures++; $display("[TB] FAIL async_reset_zn_q: got %h expected ff", zn_q); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_out_valid: got %b expected 0", out_valid); end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_exhaustive();
        logic [4:0]  vv;
        logic [31:0] tbl;
        logic [W-1:0] exp;
        tbl = EXP_ZN;
        for (int v = 0; v < 32; v++) begin
            vv = 5'(v);
            a  = {W{vv[4]}};
            b1 = {W{vv[3]}};
            b2 = {W{vv[2]}};
            c1 = {W{vv[1]}};
            c2 = {W{vv[0]}};
            in_valid = vv[0];
            exp = {W{tbl[v]}};
            #1;
            checks++;
            if (zn !== exp) begin failures++; $display("[TB] FAIL sweep_zn v=%0d: got %h expected %h", v, zn, exp); end
            tick();
            checks += 2;
            if (zn_q !== exp) begin failures++; $display("[TB] FAIL sweep_zn_q v=%0d: got %h expected %h", v, zn_q, exp); end
            if (out_valid !== vv[0]) begin failures++; $display("[TB] FAIL sweep_out_valid v=%0d: got %b expected %b", v, out_valid, vv[0]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_lanes();
        a = 8'hFF; b1 = 8'h0F; b2 = 8'h00; c1 = 8'h33; c2 = 8'h00; in_valid = 1'b1;
        #1;
        checks += 2;
        if (zn !== 8'hFC) begin failures++; $display("[TB] FAIL lanes_zn: got %h expected fc", zn); end
        if (zn_b !== 8'hFC) begin failures++; $display("[TB] FAIL lanes_zn_b: got %h expected fc", zn_b); end
        tick();
        checks += 3;
        if (zn_q !== 8'hFC) begin failures++; $display("[TB] FAIL lanes_zn_q: got %h expected fc", zn_q); end
        if (zn_q_b !== 8'hFC) begin failures++; $display("[TB] FAIL lanes_zn_q_b: got %h expected fc", zn_q_b); end
        if (out_valid_b !== 1'b1) begin failures++; $display("[TB] FAIL lanes_out_valid_b: got %b expected 1", out_valid_b); end
        in_valid = 1'b0;
    endtask

    task automatic test_bist_pass();
        int busy_cycles, done_cnt, done_at, ov_busy;
        logic [W-1:0] zn_mid;
        logic pass_at0;
        a = 8'hFF; b1 = 8'hFF; b2 = 8'h00; c1 = 8'hFF; c2 = 8'h00; in_valid = 1'b0;
        run_bist(-1, busy_cycles, done_cnt, done_at, ov_busy, zn_mid, pass_at0);
        checks += 7;
        if (busy_cycles != 33) begin failures++; $display("[TB] FAIL bist_busy_cycles: got %0d expected 33", busy_cycles); end
        if (done_cnt != 1) begin failures++; $display("[TB] FAIL bist_done_count: got %0d expected 1", done_cnt); end
        if (done_at != 33) begin failures++; $display("[TB] FAIL bist_done_cycle: got %0d expected 33", done_at); end
        if (ov_busy != 0) begin failures++; $display("[TB] FAIL bist_out_valid: got %0d expected 0", ov_busy); end
        if (zn_mid !== 8'h00) begin failures++; $display("[TB] FAIL bist_zn_ungated: got %h expected 00", zn_mid); end
        if (bist_pass !== 1'b1) begin failures++; $display("[TB] FAIL bist_pass: got %b expected 1", bist_pass); end
        if (zn_q !== 8'h00) begin failures++; $display("[TB] FAIL bist_resume_zn_q: got %h expected 00", zn_q); end
    endtask

    task automatic test_bist_fail();
        int done_cnt = 0;
        bist_start_b = 1'b1;
        tick();
        bist_start_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bist_done_b) done_cnt++;
            tick();
        end
        checks += 4;
        if (done_cnt != 1) begin failures++; $display("[TB] FAIL badgold_done_count: got %0d expected 1", done_cnt); end
        if (bist_pass_b !== 1'b0) begin failures++; $display("[TB] FAIL badgold_pass: got %b expected 0", bist_pass_b); end
        if (bist_busy_b !== 1'b0) begin failures++; $display("[TB] FAIL badgold_busy: got %b expected 0", bist_busy_b); end
        if (bist_pass !== 1'b1) begin failures++; $display("[TB] FAIL pass_sticky: got %b expected 1", bist_pass); end
    endtask

    task automatic test_reset_mid_bist();
        int done_cnt = 0;
        int busy_cnt = 0;
        int busy_cycles, done_cnt2, done_at, ov_busy;
        logic [W-1:0] zn_mid;
        logic pass_at0;
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (bist_busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", bist_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (bist_busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy: got %b expected 0", bist_busy); end
        if (bist_done !== 1'b0) begin failures++; $display("[TB] FAIL abort_done: got %b expected 0", bist_done); end
        if (bist_pass !== 1'b0) begin failures++; $display("[TB] FAIL abort_pass: got %b expected 0", bist_pass); end
        if (zn_q !== 8'hFF) begin failures++; $display("[TB] FAIL abort_zn_q: got %h expected ff", zn_q); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_out_valid: got %b expected 0", out_valid); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bist_done) done_cnt++;
            if (bist_busy) busy_cnt++;
            tick();
        end
        checks += 2;
        if (done_cnt != 0) begin failures++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
        if (busy_cnt != 0) begin failures++; $display("[TB] FAIL abort_stays_idle: got %0d expected 0", busy_cnt); end
        run_bist(-1, busy_cycles, done_cnt2, done_at, ov_busy, zn_mid, pass_at0);
        checks += 3;
        if (busy_cycles != 33) begin failures++; $display("[TB] FAIL rerun_busy_cycles: got %0d expected 33", busy_cycles); end
        if (done_cnt2 != 1) begin failures++; $display("[TB] FAIL rerun_done_count: got %0d expected 1", done_cnt2); end
        if (bist_pass !== 1'b1) begin failures++; $display("[TB] FAIL rerun_pass: got %b expected 1", bist_pass); end
    endtask

    task automatic test_back_to_back();
        int busy_cycles, done_cnt, done_at, ov_busy;
        logic [W-1:0] zn_mid;
        logic pass_at0;
        a = 8'hFF; b1 = 8'h0F; b2 = 8'h00; c1 = 8'h33; c2 = 8'h00; in_valid = 1'b1;
        run_bist(15, busy_cycles, done_cnt, done_at, ov_busy, zn_mid, pass_at0);
        checks += 7;
        if (pass_at0 !== 1'b0) begin failures++; $display("[TB] FAIL collide_pass_cleared: got %b expected 0", pass_at0); end
        if (ov_busy != 0) begin failures++; $display("[TB] FAIL collide_out_valid: got %0d expected 0", ov_busy); end
        if (busy_cycles != 33) begin failures++; $display("[TB] FAIL collide_busy_cycles: got %0d expected 33", busy_cycles); end
        if (done_at != 33) begin failures++; $display("[TB] FAIL collide_done_cycle: got %0d expected 33", done_at); end
        if (done_cnt != 1) begin failures++; $display("[TB] FAIL collide_done_count: got %0d expected 1", done_cnt); end
        if (bist_pass !== 1'b1) begin failures++; $display("[TB] FAIL collide_pass: got %b expected 1", bist_pass); end
        if (out_valid !== 1'b1 || zn_q !== 8'hFC) begin
            failures++;
            $display("[TB] FAIL collide_resume: got valid=%b zn_q=%h expected valid=1 zn_q=fc", out_valid, zn_q);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0; b1 = '0; b2 = '0; c1 = '0; c2 = '0;
        bist_start = 1'b0;
        bist_start_b = 1'b0;
        $display("[TB] starting oai221_cell_bank bench");
        test_reset();
        test_exhaustive();
        test_lanes();
        test_bist_pass();
        test_bist_fail();
        test_reset_mid_bist();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
